// File: rtl/heater_pkg.sv
// heater_pkg: FSM state type and default sizing constants for the heater lane sequencer
package heater_pkg;
  typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} heater_state_t;
  localparam int DEF_NUM_LANES = 16;
  localparam int DEF_RAMP_CYCLES = 1024;
  localparam int DEF_WARMUP_CYCLES = 4160;
  localparam int DEF_ERR_CNT_W = 16;
endpackage

// File: rtl/heater_lane_warmup.sv
// heater_lane_warmup: per-lane warmup counter, checker-clear generation and monitored flag
module heater_lane_warmup #(
  parameter int WARMUP_CYCLES = heater_pkg::DEF_WARMUP_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic rel_d,
  input  logic clr,
  output logic err_clear,
  output logic monitored
);
  localparam int CW = WARMUP_CYCLES > 0 ? $clog2(WARMUP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WL = CW'(WARMUP_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic mon_q, mon_d, err_clear_q, err_clear_d;
  // rel_d is the lane's next release state, so the window lines up with the registered lane_reset
  always_comb begin
    cnt_d = !rel_d ? '0 : (cnt_q == WL ? WL : cnt_q + CW'(1));
    mon_d = rel_d && cnt_q == WL;
    err_clear_d = !mon_d || clr;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      mon_q <= 1'b0;
      err_clear_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      mon_q <= mon_d;
      err_clear_q <= err_clear_d;
    end
  end
  assign err_clear = err_clear_q;
  assign monitored = mon_q;
endmodule

// File: rtl/heater_ctrl.sv
// heater_ctrl: staggered heater lane enable/disable sequencer with warmup-gated sticky error capture
// Option HEATER_CTRL_AUTO_STOP_EN: a newly latched lane error forces ramp-down from RAMP_UP or RUN.
module heater_ctrl
  import heater_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int RAMP_CYCLES = DEF_RAMP_CYCLES,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               stop,
  input  logic [$clog2(NUM_LANES+1)-1:0]     target_lanes,
  input  logic                               clear_errors,
  input  logic [NUM_LANES-1:0]               lane_error,
  output logic [NUM_LANES-1:0]               lane_reset,
  output logic [NUM_LANES-1:0]               lane_err_clear,
  output logic [$clog2(NUM_LANES+1)-1:0]     active_lanes,
  output logic                               busy,
  output logic [NUM_LANES-1:0]               err_mask,
  output logic [ERR_CNT_W-1:0]               err_count
);
  localparam int AW = $clog2(NUM_LANES + 1);
  localparam int TW = RAMP_CYCLES > 1 ? $clog2(RAMP_CYCLES) : 1;
  localparam int SW = ERR_CNT_W + AW;
  localparam logic [AW-1:0] NL = AW'(NUM_LANES);
  localparam logic [TW-1:0] RL = TW'(RAMP_CYCLES - 1);
  localparam logic [SW-1:0] CMAX = SW'({ERR_CNT_W{1'b1}});
  heater_state_t state_q, state_d;
  logic [AW-1:0] act_q, act_d, tgt_q, tgt_d, tgt_in;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [NUM_LANES-1:0] lane_reset_q, lane_reset_d, mon, new_err, err_mask_q, err_mask_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [SW-1:0] sum;
  logic busy_q, busy_d, blk_q, halt;
`ifdef HEATER_CTRL_AUTO_STOP_EN
  logic new_err_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) new_err_q <= 1'b0;
    else new_err_q <= |new_err;
  end
  assign halt = stop || new_err_q;
`else
  assign halt = stop;
`endif
  always_comb begin
    state_d = state_q;
    act_d = act_q;
    tmr_d = tmr_q;
    tgt_d = tgt_q;
    tgt_in = target_lanes > NL ? NL : target_lanes;
    case (state_q)
      IDLE: if (start && !stop && tgt_in != '0) begin
        state_d = tgt_in == AW'(1) ? RUN : RAMP_UP;
        act_d = AW'(1);
        tmr_d = '0;
        tgt_d = tgt_in;
      end
      RAMP_UP, RUN: if (halt) begin
        act_d = act_q - AW'(1);
        tmr_d = '0;
        state_d = act_q == AW'(1) ? IDLE : RAMP_DOWN;
      end else if (state_q == RAMP_UP) begin
        act_d = tmr_q == RL ? act_q + AW'(1) : act_q;
        tmr_d = tmr_q == RL ? '0 : tmr_q + TW'(1);
        state_d = act_d == tgt_q ? RUN : RAMP_UP;
      end
      default: begin
        act_d = tmr_q == RL ? act_q - AW'(1) : act_q;
        tmr_d = tmr_q == RL ? '0 : tmr_q + TW'(1);
        state_d = act_d == '0 ? IDLE : RAMP_DOWN;
      end
    endcase
    busy_d = state_d != IDLE;
    for (int i = 0; i < NUM_LANES; i++) lane_reset_d[i] = AW'(i) >= act_d;
    // capture is blanked in the clear cycle and the one after, so the checker clear can settle
    new_err = (clear_errors || blk_q) ? '0 : mon & lane_error & ~err_mask_q;
    sum = SW'(err_count_q);
    for (int i = 0; i < NUM_LANES; i++) sum = sum + SW'(new_err[i]);
    err_mask_d = clear_errors ? '0 : err_mask_q | new_err;
    err_count_d = clear_errors ? '0 : (sum > CMAX ? '1 : sum[ERR_CNT_W-1:0]);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      act_q <= '0;
      tgt_q <= '0;
      tmr_q <= '0;
      lane_reset_q <= '1;
      busy_q <= 1'b0;
      err_mask_q <= '0;
      err_count_q <= '0;
      blk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q <= act_d;
      tgt_q <= tgt_d;
      tmr_q <= tmr_d;
      lane_reset_q <= lane_reset_d;
      busy_q <= busy_d;
      err_mask_q <= err_mask_d;
      err_count_q <= err_count_d;
      blk_q <= clear_errors;
    end
  end
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    heater_lane_warmup #(.WARMUP_CYCLES(WARMUP_CYCLES)) u_warmup (
      .clk(clk),
      .reset(reset),
      .rel_d(!lane_reset_d[g]),
      .clr(clear_errors),
      .err_clear(lane_err_clear[g]),
      .monitored(mon[g])
    );
  end
  assign lane_reset = lane_reset_q;
  assign active_lanes = act_q;
  assign busy = busy_q;
  assign err_mask = err_mask_q;
  assign err_count = err_count_q;
endmodule

// File: doc/heater_ctrl.md
# heater_ctrl

Sequencer for an array of LFSR/BRAM/DSP heater lanes, each a generator-to-checker delay chain with its own `reset`, `err_clear` and `error`. It staggers lane enables and disables one lane at a time, which limits current steps on the power rail. It holds each newly enabled lane's checker clear until that lane's pipeline has filled, then records checker errors in a sticky mask and a saturating counter. It sits between the heater top-level register interface and the lane instances.

## Interface
- `NUM_LANES`, 16: number of heater lanes controlled.
- `RAMP_CYCLES`, 1024: clock cycles between successive lane enables or disables; must be ≥1.
- `WARMUP_CYCLES`, 4160: cycles after a lane's release before its checker is monitored; covers the full generator-to-checker latency.
- `ERR_CNT_W`, 16: width of the error counter.
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  single-cycle pulse; begins ramp-up.
- `stop`  in  1  single-cycle pulse; begins ramp-down.
- `target_lanes`  in  $clog2(NUM_LANES+1)  lane count to enable; sampled when `start` is accepted.
- `clear_errors`  in  1  single-cycle pulse; clears the error record.
- `lane_error`  in  NUM_LANES  per-lane checker error.
- `lane_reset`  out  NUM_LANES  per-lane reset; 1 holds the lane in reset.
- `lane_err_clear`  out  NUM_LANES  per-lane checker clear.
- `active_lanes`  out  $clog2(NUM_LANES+1)  number of lanes currently released.
- `busy`  out  1  high in every state except IDLE.
- `err_mask`  out  NUM_LANES  sticky per-lane error flags.
- `err_count`  out  ERR_CNT_W  saturating count of newly latched lane errors.

## Operation
- FSM states: IDLE, RAMP_UP, RUN, RAMP_DOWN.
- IDLE: every `lane_reset` bit is 1.
  - `start` with clamped target > 0 latches the target and moves to RAMP_UP.
  - `start` with target 0 is ignored.
  - A target above NUM_LANES is clamped to NUM_LANES.
- RAMP_UP: releases lanes in ascending index order.
  - Lane 0 is released in the cycle after `start` is accepted.
  - Each further lane is released RAMP_CYCLES after the previous one, and `active_lanes` increments with each release.
  - When `active_lanes` reaches the target, the FSM moves to RUN in the same cycle as the last release.
- RUN: `start` is ignored. `stop` moves to RAMP_DOWN.
- RAMP_DOWN: asserts `lane_reset` on the highest released lane first.
  - The first lane is reset in the cycle after `stop`.
  - Each further lane is reset RAMP_CYCLES after the previous one, and `active_lanes` decrements with each reset.
  - When `active_lanes` reaches 0, the FSM returns to IDLE.
- `stop` during RAMP_UP moves to RAMP_DOWN immediately; the ramp timer restarts.
- `start` during RAMP_DOWN is ignored.
- `start` and `stop` in the same cycle: `stop` wins; in IDLE, both are ignored.
- Per-lane warmup:
  - `lane_err_clear[i]` is 1 while lane i is in reset and for WARMUP_CYCLES after its release.
  - After that window, lane i is "monitored".
  - Returning lane i to reset clears its monitored status.
- Error capture:
  - `err_mask[i]` sets when lane i is monitored and `lane_error[i]` is 1.
  - `err_count` adds the number of mask bits newly set in that cycle; several lanes in one cycle add their popcount.
  - `err_count` saturates at all-ones.
- `clear_errors`:
  - Zeroes `err_mask` and `err_count`.
  - Pulses `lane_err_clear` for one cycle on every monitored lane.
  - Error capture is masked for that cycle and the next.
  - If a new error coincides with `clear_errors`, the clear wins.

## Timing
- All outputs are registered.
- Reset values: `lane_reset` and `lane_err_clear` all 1; `active_lanes` 0; `busy` 0; `err_mask` 0; `err_count` 0; FSM in IDLE.
- Asynchronous reset mid-operation forces every reset value immediately and cancels any ramp in progress.
- `err_mask` and `err_count` update one cycle after `lane_error` is sampled high.
- Lane k is released exactly 1 + k·RAMP_CYCLES cycles after `start` is accepted.
- `busy` goes high in the cycle after `start` is accepted and goes low in the cycle after the last lane is reset.

## Configuration
- Macro: `HEATER_CTRL_AUTO_STOP_EN`.
- Defined: any newly set `err_mask` bit forces RAMP_DOWN from RAMP_UP or RUN, using the normal ramp-down timing.
- Undefined: errors are recorded only and never change the FSM state.

## Structure
- Package `heater_pkg` holds:
  - `heater_state_t`, the FSM state enum.
  - The default lane-count and ramp constants.
- Sub-module `heater_lane_warmup`, one instance per lane, contains:
  - the lane's warmup counter;
  - generation of its `lane_err_clear` bit;
  - its monitored flag.

## Test plan
Bench parameters: NUM_LANES=4, RAMP_CYCLES=8, WARMUP_CYCLES=20.
- `start` with target 3 → `lane_reset` reads 1110 at +1, 1100 at +9, 1000 at +17; FSM enters RUN at +17; `busy` is high.
- `stop` in RUN → `lane_reset` reads 1100 at +1, 1110 at +9, 1111 at +17; then IDLE with `busy` at 0.
- `lane_error[1]` pulsed 10 cycles after lane 1's release → ignored. Pulsed 25 cycles after release → `err_mask` 0010 and `err_count` 1 on the next cycle. `clear_errors` → both return to 0, and `lane_err_clear[1]` pulses for 1 cycle.
- Target 7 → clamps to 4. `stop` issued after 2 releases → lane 1 reset at +1, lane 0 at +9. `start` and `stop` in the same cycle in RUN → RAMP_DOWN.
- Asynchronous `reset` asserted mid-RUN → all outputs take their reset values in that cycle, without waiting for a clock edge.
- With `HEATER_CTRL_AUTO_STOP_EN` defined: error on a monitored lane 0 in RUN → RAMP_DOWN follows, and the first lane is re-reset 1 cycle after the mask sets.
